lpc_quantizer: RTL and testbench

Quantises the ORDER floating-point LPC coefficients produced by the Levinson–Durbin stage into signed fixed-point coefficients plus a shared shift, in the form the FLAC subframe encoder needs. It sits directly downstream of the Durbin recursion and upstream of the residual calculator and bitstream writer. All arithmetic works on IEEE-754 single-precision bit fields; no floating-point IP is used.

---
 rtl/lpc_quantizer_pkg.sv | 34 +++
 rtl/lpc_quantizer_float_to_fixed.sv | 60 ++++++
 rtl/lpc_quantizer.sv | 91 +++++++++
 tb/tb_lpc_quantizer.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/lpc_quantizer_pkg.sv
// Shared definitions for the LPC coefficient quantiser: float field
// positions, exponent constants, FSM states and the shift calculation.
package lpc_quantizer_pkg;

   localparam int SIGN_BIT     = 31;
   localparam int EXP_MSB      = 30;
   localparam int EXP_LSB      = 23;
   localparam int MAN_MSB      = 22;
   localparam int EXP_BIAS     = 127;
   localparam int FREXP_OFFSET = 126;
   localparam int MAX_SHIFT    = 15;

   typedef enum logic [1:0] {
      S_COLLECT,
      S_SHIFT,
      S_EMIT,
      S_DONE
   } state_t;

   // Shared shift from the largest biased exponent of the frame.
   // emax == 0 means every coefficient is zero or denormal.
   function automatic logic [3:0] calc_shift(
      input logic [7:0] emax,
      input int         precision
   );
      int s;
      s = (precision - 1) - (int'(emax) - FREXP_OFFSET);
      if (emax == 8'd0)        return 4'd0;
      else if (s < 0)          return 4'd0;
      else if (s > MAX_SHIFT)  return 4'(MAX_SHIFT);
      else                     return 4'(s);
   endfunction

endpackage

// File: rtl/lpc_quantizer_float_to_fixed.sv
// float_to_fixed: combinational IEEE-754 single -> signed fixed point.
// Ports: iFloat (32b float), iShift (4b scale), oFixed (PRECISION bits).
module float_to_fixed
   import lpc_quantizer_pkg::*;
#(
   parameter int PRECISION = 12
) (
   input  logic [31:0]          iFloat,
   input  logic [3:0]           iShift,
   output logic [PRECISION-1:0] oFixed
);

   localparam logic [23:0] POS_LIM = 24'((1 << (PRECISION - 1)) - 1);
   localparam logic [23:0] NEG_LIM = 24'(1 << (PRECISION - 1));
   localparam logic [PRECISION-1:0] POS_SAT = {1'b0, {(PRECISION-1){1'b1}}};
   localparam logic [PRECISION-1:0] NEG_SAT = {1'b1, {(PRECISION-1){1'b0}}};

   logic                 sign;
   logic [7:0]           e;
   logic [23:0]          m;
   logic [23:0]          t;
   logic [23:0]          mag;
   logic [PRECISION-1:0] magp;
   logic                 sat;
   logic                 zero;
   int                   a;
   int                   r;

   always_comb begin
      sign = iFloat[SIGN_BIT];
      e    = iFloat[EXP_MSB:EXP_LSB];
      m    = {1'b1, iFloat[MAN_MSB:0]};
      a    = int'(e) - EXP_BIAS + int'(iShift);
      r    = 23 - a;
      t    = '0;
      mag  = '0;
      sat  = 1'b0;
      zero = 1'b0;
      if (e == 8'd0) begin
         zero = 1'b1;
      end else if (e == 8'hFF) begin
         sat = 1'b1;
      end else if (a >= PRECISION) begin
         sat = 1'b1;
      end else if (r >= 25) begin
         zero = 1'b1;
      end else begin
         // r is at least 24-PRECISION here, so r-1 is a legal right shift;
         // t[0] is the last bit shifted out, giving round-half-away.
         t   = m >> (r - 1);
         mag = (t >> 1) + {23'd0, t[0]};
         sat = sign ? (mag > NEG_LIM) : (mag > POS_LIM);
      end
      magp = mag[PRECISION-1:0];
      if (zero)     oFixed = '0;
      else if (sat) oFixed = sign ? NEG_SAT : POS_SAT;
      else          oFixed = sign ? -magp : magp;
   end

endmodule

// File: rtl/lpc_quantizer.sv
// lpc_quantizer: collects ORDER float LPC coefficients, derives a shared
// shift and emits PRECISION-bit fixed-point coefficients one per cycle.
// Ports: iClock/iReset (sync, high), iEnable, iModel/iValid in;
//        oQLP, oIndex, oShift, oValid, oDone out (all registered).
module lpc_quantizer
   import lpc_quantizer_pkg::*;
#(
   parameter int ORDER     = 12,
   parameter int PRECISION = 12
) (
   input  logic                 iClock,
   input  logic                 iReset,
   input  logic                 iEnable,
   input  logic [31:0]          iModel,
   input  logic                 iValid,
   output logic [PRECISION-1:0] oQLP,
   output logic [3:0]           oIndex,
   output logic [3:0]           oShift,
   output logic                 oValid,
   output logic                 oDone
);

   logic [31:0]          coef_buf [ORDER];
   state_t               state;
   logic [3:0]           count;
   logic [3:0]           idx;
   logic [7:0]           emax;
   logic [7:0]           in_exp;
   logic [PRECISION-1:0] q;

   assign in_exp = iModel[EXP_MSB:EXP_LSB];

   float_to_fixed #(
      .PRECISION(PRECISION)
   ) u_f2f (
      .iFloat(coef_buf[idx]),
      .iShift(oShift),
      .oFixed(q)
   );

   // Buffer needs no reset: count alone decides what is valid.
   always_ff @(posedge iClock) begin
      if (!iReset && iEnable && iValid && state == S_COLLECT)
         coef_buf[count] <= iModel;
   end

   always_ff @(posedge iClock) begin
      if (iReset) begin
         state  <= S_COLLECT;
         count  <= '0;
         idx    <= '0;
         emax   <= '0;
         oQLP   <= '0;
         oIndex <= '0;
         oShift <= '0;
         oValid <= 1'b0;
         oDone  <= 1'b0;
      end else if (iEnable) begin
         unique case (state)
            S_COLLECT: begin
               if (iValid) begin
                  count <= count + 4'd1;
                  if (in_exp > emax)
                     emax <= in_exp;
                  if (count == 4'(ORDER - 1))
                     state <= S_SHIFT;
               end
            end
            S_SHIFT: begin
               oShift <= calc_shift(emax, PRECISION);
               idx    <= '0;
               state  <= S_EMIT;
            end
            S_EMIT: begin
               oValid <= 1'b1;
               oQLP   <= q;
               oIndex <= idx;
               idx    <= idx + 4'd1;
               if (idx == 4'(ORDER - 1))
                  state <= S_DONE;
            end
            S_DONE: begin
               oValid <= 1'b0;
               oDone  <= 1'b1;
            end
            default: state <= S_COLLECT;
         endcase
      end
   end

endmodule

// File: tb/tb_lpc_quantizer.sv
// Testbench for lpc_quantizer (ORDER=4, PRECISION=12): directed frames
// plus random frames against a real-arithmetic reference model.
module tb_lpc_quantizer;

   localparam int ORD  = 4;
   localparam int PREC = 12;

   typedef logic [31:0] frame_t [ORD];

   logic            iClock = 1'b0;
   logic            iReset = 1'b1;
   logic            iEnable = 1'b1;
   logic [31:0]     iModel = '0;
   logic            iValid = 1'b0;
   logic [PREC-1:0] oQLP;
   logic [3:0]      oIndex;
   logic [3:0]      oShift;
   logic            oValid;
   logic            oDone;

   int checks = 0;
   int failures = 0;

   lpc_quantizer #(
      .ORDER(ORD),
      .PRECISION(PREC)
   ) dut (
      .iClock(iClock),
      .iReset(iReset),
      .iEnable(iEnable),
      .iModel(iModel),
      .iValid(iValid),
      .oQLP(oQLP),
      .oIndex(oIndex),
      .oShift(oShift),
      .oValid(oValid),
      .oDone(oDone)
   );

   always #5 iClock = ~iClock;

   task automatic tick();
      @(posedge iClock);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         failures++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
      end
   endtask

   // Shared shift: frexp exponent of the largest magnitude.
   function automatic int ref_shift(input frame_t v);
      int emax;
      int s;
      emax = 0;
      for (int i = 0; i < ORD; i++)
         if (int'(v[i][30:23]) > emax) emax = int'(v[i][30:23]);
      if (emax == 0) return 0;
      s = (PREC - 1) - (emax - 126);
      if (s < 0) s = 0;
      if (s > 15) s = 15;
      return s;
   endfunction

   // Value scaled by 2^sh, rounded half away from zero, saturated.
   function automatic int ref_q(input logic [31:0] f, input int sh);
      int  e;
      real val;
      real mag;
      int  lim_p;
      int  lim_n;
      lim_p = (1 << (PREC - 1)) - 1;
      lim_n = 1 << (PREC - 1);
      e = int'(f[30:23]);
      if (e == 0) return 0;
      if (e == 255) return f[31] ? -lim_n : lim_p;
      val = (1.0 + real'(f[22:0]) / 8388608.0) * (2.0 ** (e - 127));
      mag = $floor(val * (2.0 ** sh) + 0.5);
      if (!f[31] && mag > real'(lim_p)) return lim_p;
      if (f[31] && mag > real'(lim_n)) return -lim_n;
      return f[31] ? -int'(mag) : int'(mag);
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_qlp"}, 32'(oQLP), 32'd0);
      check({tag, "_idx"}, 32'(oIndex), 32'd0);
      check({tag, "_shift"}, 32'(oShift), 32'd0);
      check({tag, "_valid"}, 32'(oValid), 32'd0);
      check({tag, "_done"}, 32'(oDone), 32'd0);
   endtask

   task automatic run_frame(input string tag, input frame_t v,
                            input bit gaps, input int stall_at,
                            input int abort_at, input bit extra);
      int sh;
      logic [PREC-1:0] exq;
      sh = ref_shift(v);
      for (int i = 0; i < ORD; i++) begin
         if (gaps) begin
            repeat ($urandom_range(0, 3)) begin
               if ($urandom_range(0, 1) == 0) begin
                  iValid = 1'b0;
               end else begin
                  iEnable = 1'b0;
                  iValid  = 1'b1;
                  iModel  = $urandom;
               end
               tick();
               iEnable = 1'b1;
               iValid  = 1'b0;
            end
         end
         iModel = v[i];
         iValid = 1'b1;
         tick();
         iValid = extra;
         iModel = $urandom;
      end
      check({tag, "_lat0"}, 32'(oValid), 32'd0);
      tick();
      check({tag, "_lat1"}, 32'(oValid), 32'd0);
      tick();
      for (int k = 0; k < ORD; k++) begin
         exq = PREC'(ref_q(v[k], sh));
         check({tag, "_valid"}, 32'(oValid), 32'd1);
         check({tag, "_idx"}, 32'(oIndex), 32'(k));
         check({tag, "_shift"}, 32'(oShift), 32'(sh));
         check({tag, "_qlp"}, 32'(oQLP), 32'(exq));
         check({tag, "_ndone"}, 32'(oDone), 32'd0);
         if (k == abort_at) begin
            iValid = 1'b0;
            iReset = 1'b1;
            tick();
            check_idle({tag, "_abort"});
            iReset = 1'b0;
            return;
         end
         if (k == stall_at) begin
            iEnable = 1'b0;
            repeat (3) begin
               tick();
               check({tag, "_stv"}, 32'(oValid), 32'd1);
               check({tag, "_sti"}, 32'(oIndex), 32'(k));
               check({tag, "_stq"}, 32'(oQLP), 32'(exq));
            end
            iEnable = 1'b1;
         end
         tick();
      end
      check({tag, "_done"}, 32'(oDone), 32'd1);
      check({tag, "_vfall"}, 32'(oValid), 32'd0);
      tick();
      tick();
      check({tag, "_sticky"}, 32'(oDone), 32'd1);
      check({tag, "_idle"}, 32'(oValid), 32'd0);
      check({tag, "_shold"}, 32'(oShift), 32'(sh));
      iValid = 1'b0;
   endtask

   task automatic pulse_reset(input string tag);
      iValid = 1'b0;
      iReset = 1'b1;
      tick();
      check_idle(tag);
      iReset = 1'b0;
   endtask

   function automatic logic [31:0] rand_float();
      int sel;
      sel = $urandom_range(0, 19);
      if (sel < 2) return 32'h0000_0000;
      if (sel == 2) return {1'($urandom_range(0, 1)), 8'hFF, 23'd0};
      return {1'($urandom_range(0, 1)), 8'($urandom_range(105, 135)),
              23'($urandom)};
   endfunction

   initial begin
      frame_t f;
      iReset = 1'b1;
      tick();
      tick();
      check_idle("reset");
      iReset = 1'b0;

      f = '{32'h3FC0_0000, 32'hBF40_0000, 32'h0000_0000, 32'h3A80_0000};
      run_frame("basic", f, 1'b0, -1, -1, 1'b0);
      pulse_reset("r1");

      f = '{32'h3FFF_FE5D, 32'hBFFF_FE5D, 32'h3F80_0000, 32'h3F80_0000};
      run_frame("sat", f, 1'b0, -1, -1, 1'b0);
      pulse_reset("r2");

      f = '{32'h3A80_0000, 32'h3700_0000, 32'hBA80_0000, 32'h0000_0000};
      run_frame("clamphi", f, 1'b0, -1, -1, 1'b0);
      pulse_reset("r3");

      f = '{32'h4580_0000, 32'h4060_0000, 32'hC060_0000, 32'h3F00_0000};
      run_frame("clamplo", f, 1'b0, -1, -1, 1'b1);
      pulse_reset("r4");

      f = '{32'h0, 32'h8000_0000, 32'h0000_0001, 32'h0};
      run_frame("zeros", f, 1'b0, -1, -1, 1'b0);
      pulse_reset("r5");

      f = '{32'h3FC0_0000, 32'hBF40_0000, 32'h0000_0000, 32'h3A80_0000};
      run_frame("stall", f, 1'b1, 1, -1, 1'b0);
      pulse_reset("r6");
      run_frame("abort", f, 1'b1, 1, 2, 1'b0);
      run_frame("after", f, 1'b0, -1, -1, 1'b0);
      pulse_reset("r7");

      for (int n = 0; n < 12; n++) begin
         for (int i = 0; i < ORD; i++) f[i] = rand_float();
         run_frame("rand", f, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 5)) - 1, -1,
                   1'($urandom_range(0, 1)));
         pulse_reset("rr");
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1, "timeout");
   end

endmodule
